// File: rtl/alu_unit.sv
// Integer ALU for the RV32 execute stage with a registered result (one-cycle latency).
// Optional RV32M multiplies (opcodes 16-19) are enabled by defining ALU_MUL_EN.
module alu_unit #(
   parameter int DATA_W = 32,
   parameter int INST_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INST_W-1:0] alu_inst_i,
   input  logic [DATA_W-1:0] alu_src1_i,
   input  logic [DATA_W-1:0] alu_src2_i,
   output logic [DATA_W-1:0] alu_result_o
);

   localparam int SHAMT_W = $clog2(DATA_W);

   localparam logic [INST_W-1:0] ALU_ADD       = INST_W'(0);
   localparam logic [INST_W-1:0] ALU_SUB       = INST_W'(1);
   localparam logic [INST_W-1:0] ALU_AND       = INST_W'(2);
   localparam logic [INST_W-1:0] ALU_OR        = INST_W'(3);
   localparam logic [INST_W-1:0] ALU_XOR       = INST_W'(4);
   localparam logic [INST_W-1:0] ALU_SLL       = INST_W'(5);
   localparam logic [INST_W-1:0] ALU_SRL       = INST_W'(6);
   localparam logic [INST_W-1:0] ALU_SRA       = INST_W'(7);
   localparam logic [INST_W-1:0] ALU_CMP_LESS  = INST_W'(8);
   localparam logic [INST_W-1:0] ALU_CMP_LESSU = INST_W'(9);
   localparam logic [INST_W-1:0] ALU_CMP_EQ    = INST_W'(10);
   localparam logic [INST_W-1:0] ALU_CMP_NEQ   = INST_W'(11);
   localparam logic [INST_W-1:0] ALU_CMP_GTE   = INST_W'(12);
   localparam logic [INST_W-1:0] ALU_CMP_GTEU  = INST_W'(13);
   localparam logic [INST_W-1:0] ALU_PASS2     = INST_W'(14);
   localparam logic [INST_W-1:0] ALU_PASS1     = INST_W'(15);
`ifdef ALU_MUL_EN
   localparam logic [INST_W-1:0] ALU_MUL       = INST_W'(16);
   localparam logic [INST_W-1:0] ALU_MULH      = INST_W'(17);
   localparam logic [INST_W-1:0] ALU_MULHSU    = INST_W'(18);
   localparam logic [INST_W-1:0] ALU_MULHU     = INST_W'(19);
`endif

   // Compare results are widened to a full word holding 0 or 1.
   function automatic logic [DATA_W-1:0] flag_word(input logic flag);
      return {{(DATA_W-1){1'b0}}, flag};
   endfunction

   logic signed [DATA_W-1:0]  src1_s;
   logic signed [DATA_W-1:0]  src2_s;
   logic        [SHAMT_W-1:0] shamt;
   logic        [DATA_W-1:0]  result_p0;
   logic        [DATA_W-1:0]  result_p1;

   assign src1_s = $signed(alu_src1_i);
   assign src2_s = $signed(alu_src2_i);
   assign shamt  = alu_src2_i[SHAMT_W-1:0];

`ifdef ALU_MUL_EN
   // All three products fit in 2*DATA_W bits, so a double-width multiply is exact.
   logic signed [2*DATA_W-1:0] prod_ss;
   logic signed [2*DATA_W-1:0] prod_su;
   logic        [2*DATA_W-1:0] prod_uu;

   assign prod_ss = $signed({{DATA_W{alu_src1_i[DATA_W-1]}}, alu_src1_i}) *
                    $signed({{DATA_W{alu_src2_i[DATA_W-1]}}, alu_src2_i});
   assign prod_su = $signed({{DATA_W{alu_src1_i[DATA_W-1]}}, alu_src1_i}) *
                    $signed({{DATA_W{1'b0}}, alu_src2_i});
   assign prod_uu = {{DATA_W{1'b0}}, alu_src1_i} * {{DATA_W{1'b0}}, alu_src2_i};
`endif

   // Stage p0: combinational operation select
   always_comb begin
      result_p0 = '0;
      case (alu_inst_i)
         ALU_ADD:       result_p0 = alu_src1_i + alu_src2_i;
         ALU_SUB:       result_p0 = alu_src1_i - alu_src2_i;
         ALU_AND:       result_p0 = alu_src1_i & alu_src2_i;
         ALU_OR:        result_p0 = alu_src1_i | alu_src2_i;
         ALU_XOR:       result_p0 = alu_src1_i ^ alu_src2_i;
         ALU_SLL:       result_p0 = alu_src1_i << shamt;
         ALU_SRL:       result_p0 = alu_src1_i >> shamt;
         ALU_SRA:       result_p0 = src1_s >>> shamt;
         ALU_CMP_LESS:  result_p0 = flag_word(src1_s < src2_s);
         ALU_CMP_LESSU: result_p0 = flag_word(alu_src1_i < alu_src2_i);
         ALU_CMP_EQ:    result_p0 = flag_word(alu_src1_i == alu_src2_i);
         ALU_CMP_NEQ:   result_p0 = flag_word(alu_src1_i != alu_src2_i);
         ALU_CMP_GTE:   result_p0 = flag_word(src1_s >= src2_s);
         ALU_CMP_GTEU:  result_p0 = flag_word(alu_src1_i >= alu_src2_i);
         ALU_PASS2:     result_p0 = alu_src2_i;
         ALU_PASS1:     result_p0 = alu_src1_i;
`ifdef ALU_MUL_EN
         ALU_MUL:       result_p0 = prod_ss[DATA_W-1:0];
         ALU_MULH:      result_p0 = prod_ss[2*DATA_W-1:DATA_W];
         ALU_MULHSU:    result_p0 = prod_su[2*DATA_W-1:DATA_W];
         ALU_MULHU:     result_p0 = prod_uu[2*DATA_W-1:DATA_W];
`endif
         default:       result_p0 = '0;
      endcase
   end

   // Stage p1: EX/MEM result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p1 <= '0;
      end else begin
         result_p1 <= result_p0;
      end
   end

   assign alu_result_o = result_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: table-driven vectors through a scoreboard queue,
// plus hand-written reset and back-to-back sequences. Honours ALU_MUL_EN.
module tb_alu_unit;

   localparam int DATA_W = 32;
   localparam int INST_W = 5;

   typedef struct {
      string       name;
      logic [4:0]  inst;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] exp;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic [INST_W-1:0] alu_inst_i;
   logic [DATA_W-1:0] alu_src1_i;
   logic [DATA_W-1:0] alu_src2_i;
   logic [DATA_W-1:0] alu_result_o;

   int checks = 0;
   int errors = 0;

   vec_t        vecs[$];
   logic [31:0] sb_exp[$];
   string       sb_name[$];

   alu_unit #(.DATA_W(DATA_W), .INST_W(INST_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_inst_i   (alu_inst_i),
      .alu_src1_i   (alu_src1_i),
      .alu_src2_i   (alu_src2_i),
      .alu_result_o (alu_result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [4:0] inst,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      vec_t v;
      v.name = name; v.inst = inst; v.src1 = a; v.src2 = b; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Drive one op, push its expectation, then pop and compare after the capturing edge.
   task automatic issue(input string name, input logic [4:0] inst,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      alu_inst_i = inst;
      alu_src1_i = a;
      alu_src2_i = b;
      sb_exp.push_back(exp);
      sb_name.push_back(name);
      @(posedge clk);
      #1;
      if (sb_exp.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
         check(sb_name.pop_front(), alu_result_o, sb_exp.pop_front());
      end
   endtask

   initial begin
      add_vec("add_basic",   5'd0,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C);
      add_vec("add_wrap",    5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      add_vec("add_ovf",     5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
      add_vec("sub_wrap",    5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
      add_vec("sub_basic",   5'd1,  32'h0000_0100, 32'h0000_0001, 32'h0000_00FF);
      add_vec("and",         5'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
      add_vec("or",          5'd3,  32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011);
      add_vec("xor",         5'd4,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
      add_vec("sll_31",      5'd5,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
      add_vec("sll_0",       5'd5,  32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678);
      add_vec("sll_4",       5'd5,  32'h1234_5678, 32'h0000_0004, 32'h2345_6780);
      add_vec("srl_21",      5'd6,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000);
      add_vec("sra_21",      5'd7,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
      add_vec("sra_31",      5'd7,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);
      add_vec("sra_pos",     5'd7,  32'h4000_0000, 32'h0000_0004, 32'h0400_0000);
      add_vec("sra_0",       5'd7,  32'h8765_4321, 32'h0000_0040, 32'h8765_4321);
      add_vec("less_t",      5'd8,  32'h8FFF_FF00, 32'hFFFF_FFFF, 32'h0000_0001);
      add_vec("less_f",      5'd8,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("lessu_t",     5'd9,  32'h8FFF_FF00, 32'hFFFF_FFFF, 32'h0000_0001);
      add_vec("lessu_f",     5'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      add_vec("eq_t",        5'd10, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001);
      add_vec("eq_f",        5'd10, 32'h0000_1234, 32'h0000_1235, 32'h0000_0000);
      add_vec("neq_f",       5'd11, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000);
      add_vec("neq_t",       5'd11, 32'h8000_1234, 32'h0000_1234, 32'h0000_0001);
      add_vec("gte_eq",      5'd12, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001);
      add_vec("gte_f",       5'd12, 32'h8FFF_FF00, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("gte_t",       5'd12, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
      add_vec("gteu_f",      5'd13, 32'h8FFF_FF00, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("gteu_t",      5'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
      add_vec("pass2",       5'd14, 32'h1111_1111, 32'hABCD_0000, 32'hABCD_0000);
      add_vec("pass1",       5'd15, 32'h1111_1111, 32'hABCD_0000, 32'h1111_1111);
      add_vec("undef_20",    5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("undef_30",    5'd30, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000);
      add_vec("undef_31",    5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
`ifdef ALU_MUL_EN
      add_vec("mul",         5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      add_vec("mulh",        5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("mulhsu",      5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      add_vec("mulhu",       5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      add_vec("mul_big",     5'd16, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
      add_vec("mulhu_big",   5'd19, 32'h0001_0000, 32'h0001_0003, 32'h0000_0001);
      add_vec("mulh_neg",    5'd17, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF);
`else
      add_vec("mul_off",     5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("mulh_off",    5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("mulhsu_off",  5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      add_vec("mulhu_off",   5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
`endif

      rst_n      = 1'b0;
      alu_inst_i = 5'd0;
      alu_src1_i = 32'h0000_0005;
      alu_src2_i = 32'h0000_0007;
      #1;
      check("reset_initial", alu_result_o, 32'h0);
      @(posedge clk);
      #1;
      check("reset_held_edge", alu_result_o, 32'h0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_op_after_reset", alu_result_o, 32'h0000_000C);

      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].name, vecs[i].inst, vecs[i].src1, vecs[i].src2, vecs[i].exp);
      end

      // Back-to-back alternation: each result appears one cycle after issue.
      for (int i = 0; i < 3; i++) begin
         issue("b2b_xor",   5'd4,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
         issue("b2b_pass2", 5'd14, 32'h0000_0000, 32'hABCD_0000, 32'hABCD_0000);
      end
      issue("b2b_undef30", 5'd30, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0000_0000);

      // Mid-cycle async reset with add 5+7 pending, after a nonzero result.
      issue("pre_reset_nonzero", 5'd15, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
      alu_inst_i = 5'd0;
      alu_src1_i = 32'h0000_0005;
      alu_src2_i = 32'h0000_0007;
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", alu_result_o, 32'h0);
      alu_inst_i = 'x;
      alu_src1_i = 'x;
      alu_src2_i = 'x;
      @(posedge clk);
      #1;
      check("reset_x_inputs", alu_result_o, 32'h0);
      alu_inst_i = 5'd0;
      alu_src1_i = 32'h0000_0005;
      alu_src2_i = 32'h0000_0007;
      #2;
      rst_n = 1'b1;
      #1;
      check("release_holds_zero", alu_result_o, 32'h0);
      @(posedge clk);
      #1;
      check("add_after_release", alu_result_o, 32'h0000_000C);

      if (sb_exp.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_exp.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1, "timeout");
   end

endmodule
